pc_stack: RTL and testbench

Parametrised program counter for the basic-computer datapath: clear, load, increment and skip, plus call/return through an internal return-address stack. It replaces the fixed 12-bit load/increment PC and drives the address path to AR and memory. Commands resolve by fixed priority, so simultaneous control signals from the control unit are well defined.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_stack_if.sv | 32 +++
 rtl/pc_stack_ret_stack.sv | 50 +++++
 rtl/pc_stack.sv | 97 +++++++++
 tb/tb_pc_stack.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program counter: command encoding and strobe priority encoder.
// Pure combinational helpers; no state.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INR,
    OP_SKIP,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // Ret > Call > Load > Skip > INR; exactly one command wins.
  function automatic pc_op_t pc_decode(input logic ret, input logic call, input logic load,
                                       input logic skip, input logic inr);
    pc_op_t op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (load) op = OP_LOAD;
    else if (skip) op = OP_SKIP;
    else if (inr)  op = OP_INR;
    else           op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Command strobes and status bundle between the control unit (master) and the PC (slave).
// Latency 1 cycle per command; no backpressure, a command may be issued every cycle.
interface pc_stack_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             Data;
  logic                         Load;
  logic                         INR;
  logic                         Skip;
  logic                         Call;
  logic                         Ret;
  logic                         ClrErr;
  logic [WIDTH-1:0]             Q;
  logic [WIDTH-1:0]             Top;
  logic [$clog2(DEPTH+1)-1:0]   Count;
  logic                         Full;
  logic                         Empty;
  logic                         Wrap;
  logic                         OvfErr;
  logic                         UndErr;

  modport master (
    output Data, Load, INR, Skip, Call, Ret, ClrErr,
    input  Q, Top, Count, Full, Empty, Wrap, OvfErr, UndErr
  );

  modport slave (
    input  Data, Load, INR, Skip, Call, Ret, ClrErr,
    output Q, Top, Count, Full, Empty, Wrap, OvfErr, UndErr
  );
endinterface

// File: rtl/pc_stack_ret_stack.sv
// LIFO of return addresses; rejects push when full and pop when empty and reports it.
// Push/pop take effect at the next edge; Top/Full/Empty decode from registered count only.
module ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_dat,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       push_rej,
  output logic                       pop_rej
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_rej = push & full;
  assign pop_rej  = pop & empty;
  assign wr_idx   = IW'(cnt_q);
  assign rd_idx   = IW'(cnt_q - CW'(1));
  assign top      = empty ? '0 : mem[rd_idx];
  assign count    = cnt_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Contents are meaningless above the count, so storage needs no reset.
  always_ff @(posedge CLK) begin
    if (push && !full) mem[wr_idx] <= push_dat;
  end
endmodule

// File: rtl/pc_stack.sv
// Program counter with load/increment/skip and call/return through a return-address stack.
// Latency 1 cycle for every command; no backpressure, rejected Call/Ret only raise sticky flags.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input logic        CLK,
  input logic        CLR,
  pc_stack_if.slave  bus
);
  pc_op_t           op;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   sum;
  logic [1:0]       step;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             ovf_r;
  logic             und_r;
  logic             push;
  logic             pop;
  logic             push_rej;
  logic             pop_rej;
  logic [WIDTH-1:0] top;

  assign op   = pc_decode(bus.Ret, bus.Call, bus.Load, bus.Skip, bus.INR);
  assign push = (op == OP_CALL);
  assign pop  = (op == OP_RET);

  always_comb begin
    step = 2'd0;
    if (op == OP_SKIP)                      step = 2'd2;
    else if (op == OP_INR || op == OP_CALL) step = 2'd1;
  end

  // Carry is bit WIDTH of the widened sum and never reaches Q.
  assign sum = {1'b0, q_r} + {{(WIDTH-1){1'b0}}, step};

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    case (op)
      OP_INR, OP_SKIP: begin
        q_nxt    = sum[WIDTH-1:0];
        wrap_nxt = sum[WIDTH];
      end
      OP_LOAD: q_nxt = bus.Data;
      OP_CALL: begin
        if (!push_rej) begin
          q_nxt    = bus.Data;
          wrap_nxt = sum[WIDTH];
        end
      end
      OP_RET:  if (!pop_rej) q_nxt = top;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
      und_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
      // An error in the same cycle as ClrErr keeps the flag set.
      if (push_rej)        ovf_r <= 1'b1;
      else if (bus.ClrErr) ovf_r <= 1'b0;
      if (pop_rej)         und_r <= 1'b1;
      else if (bus.ClrErr) und_r <= 1'b0;
    end
  end

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .CLK      (CLK),
    .CLR      (CLR),
    .push     (push),
    .pop      (pop),
    .push_dat (sum[WIDTH-1:0]),
    .top      (top),
    .count    (bus.Count),
    .full     (bus.Full),
    .empty    (bus.Empty),
    .push_rej (push_rej),
    .pop_rej  (pop_rej)
  );

  assign bus.Q      = q_r;
  assign bus.Top    = top;
  assign bus.Wrap   = wrap_r;
  assign bus.OvfErr = ovf_r;
  assign bus.UndErr = und_r;
endmodule

// File: tb/tb_pc_stack.sv
// Directed vector bench for pc_stack (WIDTH=12, DEPTH=4) plus an async-reset sequence.
module tb_pc_stack;
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] R = 6'b100000;
  localparam logic [5:0] C = 6'b010000;
  localparam logic [5:0] L = 6'b001000;
  localparam logic [5:0] S = 6'b000100;
  localparam logic [5:0] I = 6'b000010;
  localparam logic [5:0] E = 6'b000001;

  typedef struct {
    logic [5:0]  cmd;
    logic [11:0] data;
    logic [11:0] q;
    logic [2:0]  cnt;
    logic [11:0] top;
    logic        wrap;
    logic        ovf;
    logic        und;
  } vec_t;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  vec_t vq[$];

  pc_stack_if #(.WIDTH(12), .DEPTH(4)) bus ();

  pc_stack #(.WIDTH(12), .DEPTH(4)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [5:0] cmd, input logic [11:0] data,
                              input logic [11:0] q, input logic [2:0] cnt,
                              input logic [11:0] top, input logic wrap,
                              input logic ovf, input logic und);
    vec_t v;
    v.cmd = cmd; v.data = data; v.q = q; v.cnt = cnt; v.top = top;
    v.wrap = wrap; v.ovf = ovf; v.und = und;
    return v;
  endfunction

  task automatic drive(input logic [5:0] cmd, input logic [11:0] data);
    {bus.Ret, bus.Call, bus.Load, bus.Skip, bus.INR, bus.ClrErr} = cmd;
    bus.Data = data;
  endtask

  task automatic check(input string nm, input logic [11:0] q, input logic [2:0] cnt,
                       input logic [11:0] top, input logic wrap, input logic ovf,
                       input logic und);
    logic e;
    logic f;
    e = (cnt == 3'd0);
    f = (cnt == 3'd4);
    vecs++;
    if (bus.Q !== q || bus.Count !== cnt || bus.Top !== top || bus.Wrap !== wrap ||
        bus.OvfErr !== ovf || bus.UndErr !== und || bus.Empty !== e || bus.Full !== f) begin
      errs++;
      $display("FAIL %s: got Q=%h Count=%0d Top=%h Wrap=%b Ovf=%b Und=%b Empty=%b Full=%b, expected Q=%h Count=%0d Top=%h Wrap=%b Ovf=%b Und=%b Empty=%b Full=%b",
               nm, bus.Q, bus.Count, bus.Top, bus.Wrap, bus.OvfErr, bus.UndErr, bus.Empty,
               bus.Full, q, cnt, top, wrap, ovf, und, e, f);
    end
  endtask

  initial begin
    //                cmd      data     q        cnt  top      w  o  u
    vq.push_back(mk(L,         12'h0FF, 12'h0FF, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(I,         12'h000, 12'h100, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(I,         12'h000, 12'h101, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(L,         12'hFFF, 12'hFFF, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(I,         12'h000, 12'h000, 3'd0, 12'h000, 1, 0, 0));
    vq.push_back(mk(N,         12'h000, 12'h000, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(L,         12'hFFE, 12'hFFE, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(S,         12'h000, 12'h000, 3'd0, 12'h000, 1, 0, 0));
    vq.push_back(mk(L,         12'h010, 12'h010, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(C,         12'h200, 12'h200, 3'd1, 12'h011, 0, 0, 0));
    vq.push_back(mk(C,         12'h300, 12'h300, 3'd2, 12'h201, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h201, 3'd1, 12'h011, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h011, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(C,         12'h100, 12'h100, 3'd1, 12'h012, 0, 0, 0));
    vq.push_back(mk(C,         12'h200, 12'h200, 3'd2, 12'h101, 0, 0, 0));
    vq.push_back(mk(C,         12'h300, 12'h300, 3'd3, 12'h201, 0, 0, 0));
    vq.push_back(mk(C,         12'h400, 12'h400, 3'd4, 12'h301, 0, 0, 0));
    vq.push_back(mk(C,         12'h500, 12'h400, 3'd4, 12'h301, 0, 1, 0));
    vq.push_back(mk(E,         12'h000, 12'h400, 3'd4, 12'h301, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h301, 3'd3, 12'h201, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h201, 3'd2, 12'h101, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h101, 3'd1, 12'h012, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h012, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h012, 3'd0, 12'h000, 0, 0, 1));
    vq.push_back(mk(R | E,     12'h000, 12'h012, 3'd0, 12'h000, 0, 0, 1));
    vq.push_back(mk(E,         12'h000, 12'h012, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(C,         12'h040, 12'h040, 3'd1, 12'h013, 0, 0, 0));
    vq.push_back(mk(R|C|L|I,   12'h777, 12'h013, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(L,         12'hFFF, 12'hFFF, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(C,         12'h050, 12'h050, 3'd1, 12'h000, 1, 0, 0));
    vq.push_back(mk(S | I,     12'h000, 12'h052, 3'd1, 12'h000, 0, 0, 0));
    vq.push_back(mk(R,         12'h000, 12'h000, 3'd0, 12'h000, 0, 0, 0));
    vq.push_back(mk(S,         12'h000, 12'h002, 3'd0, 12'h000, 0, 0, 0));

    drive(N, 12'h000);
    #12;
    check("reset_state", 12'h000, 3'd0, 12'h000, 0, 0, 0);
    @(negedge CLK);
    CLR = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].cmd, vq[i].data);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i), vq[i].q, vq[i].cnt, vq[i].top, vq[i].wrap,
            vq[i].ovf, vq[i].und);
      @(negedge CLK);
    end

    // Build a three-deep call chain, then drop reset between edges.
    drive(C, 12'h010);
    @(posedge CLK); #1;
    check("chain_call1", 12'h010, 3'd1, 12'h003, 0, 0, 0);
    @(negedge CLK);
    drive(C, 12'h020);
    @(posedge CLK); #1;
    check("chain_call2", 12'h020, 3'd2, 12'h011, 0, 0, 0);
    @(negedge CLK);
    drive(C, 12'h030);
    @(posedge CLK); #1;
    check("chain_call3", 12'h030, 3'd3, 12'h021, 0, 0, 0);
    drive(N, 12'h000);
    #1;
    CLR = 1'b0;
    #1;
    check("async_reset", 12'h000, 3'd0, 12'h000, 0, 0, 0);

    @(negedge CLK);
    CLR = 1'b1;
    drive(L, 12'h123);
    @(posedge CLK); #1;
    check("first_after_reset", 12'h123, 3'd0, 12'h000, 0, 0, 0);
    @(negedge CLK);
    drive(R, 12'h000);
    @(posedge CLK); #1;
    check("ret_after_reset", 12'h123, 3'd0, 12'h000, 0, 0, 1);
    @(negedge CLK);
    drive(N, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
